// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Inter-stage pipeline register (F/D, D/X, X/M, M/W). Carries a valid bit,
//   the instruction word, the PC and NUM_DATA operand words. It supports
//   stall (hold the current contents) and flush (insert a bubble). An
//   optional saturating stall-cycle counter is available for hazard
//   profiling.
//
//   Every edge performs exactly one action, in priority order:
//   reset > flush > stall > load.
//   All outputs come straight from flops. No input reaches an output
//   combinationally.
//
// Configuration macro:
//   PIPE_STALL_CNT_EN
//     - defined:   the stall counter flops are implemented and stall_cnt is
//                  live.
//     - undefined: there are no counter flops and stall_cnt is tied to 0.
//                  The port keeps its STALL_CNT_W width.
//
// Ports:
//   clock      in   1                rising-edge clock
//   reset      in   1                asynchronous, active-high reset
//   stall      in   1                hold current contents this cycle
//   flush      in   1                load a bubble at the next edge
//   valid_in   in   1                upstream slot holds a real instruction
//   insn_in    in   INSN_W           instruction from upstream stage
//   pc_in      in   PC_W             PC+4 from upstream stage
//   data_in    in   NUM_DATA*DATA_W  operand words, word k at [k*DATA_W +: DATA_W]
//   valid_out  out  1                registered valid
//   insn_out   out  INSN_W           registered instruction
//   pc_out     out  PC_W             registered PC
//   data_out   out  NUM_DATA*DATA_W  registered operands, same packing
//   stall_cnt  out  STALL_CNT_W      consecutive held-valid cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int INSN_W      = 32,
   parameter int PC_W        = 12,
   parameter int DATA_W      = 32,
   parameter int NUM_DATA    = 2,
   parameter int STALL_CNT_W = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         valid_in,
   input  logic [INSN_W-1:0]            insn_in,
   input  logic [PC_W-1:0]              pc_in,
   input  logic [NUM_DATA*DATA_W-1:0]   data_in,
   output logic                         valid_out,
   output logic [INSN_W-1:0]            insn_out,
   output logic [PC_W-1:0]              pc_out,
   output logic [NUM_DATA*DATA_W-1:0]   data_out,
   output logic [STALL_CNT_W-1:0]       stall_cnt
);

   localparam int DW = NUM_DATA * DATA_W;

   logic          r_valid;
   logic [INSN_W-1:0] r_insn;
   logic [PC_W-1:0]   r_pc;
   logic [DW-1:0]     r_data;

   // Next-state selection for the payload register.
   // A flush forces a bubble. An all-zero instruction word is the ISA nop,
   // so the whole slot is cleared, not just valid.
   logic              w_valid_nxt;
   logic [INSN_W-1:0] w_insn_nxt;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [DW-1:0]     w_data_nxt;

   // Payload next-state: flush > stall > load
   always_comb begin
      w_valid_nxt = r_valid;
      w_insn_nxt  = r_insn;
      w_pc_nxt    = r_pc;
      w_data_nxt  = r_data;
      if (flush) begin
         w_valid_nxt = 1'b0;
         w_insn_nxt  = '0;
         w_pc_nxt    = '0;
         w_data_nxt  = '0;
      end else if (stall) begin
         w_valid_nxt = r_valid;
         w_insn_nxt  = r_insn;
         w_pc_nxt    = r_pc;
         w_data_nxt  = r_data;
      end else begin
         // The payload is copied even when valid_in=0. Downstream qualifies
         // it with valid_out.
         w_valid_nxt = valid_in;
         w_insn_nxt  = insn_in;
         w_pc_nxt    = pc_in;
         w_data_nxt  = data_in;
      end
   end

   // Payload register with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_insn  <= '0;
         r_pc    <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_insn  <= w_insn_nxt;
         r_pc    <= w_pc_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign valid_out = r_valid;
   assign insn_out  = r_insn;
   assign pc_out    = r_pc;
   assign data_out  = r_data;

`ifdef PIPE_STALL_CNT_EN
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;

   // Stall counter next-state.
   // The counter counts only edges that hold a real instruction. A hold of
   // a bubble leaves the count unchanged. Any load or flush clears it.
   always_comb begin
      w_stall_cnt_nxt = r_stall_cnt;
      if (flush) begin
         w_stall_cnt_nxt = '0;
      end else if (stall) begin
         if (r_valid && (r_stall_cnt != CNT_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
         end else begin
            w_stall_cnt_nxt = r_stall_cnt;
         end
      end else begin
         w_stall_cnt_nxt = '0;
      end
   end

   // Stall counter register with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else begin
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   logic clock;
   logic reset;
   logic stall;
   logic flush;
   logic valid_in;
   logic [31:0] insn_in;
   logic [11:0] pc_in;
   logic [63:0] da_in;
   logic [63:0] db_in;
   logic [15:0] dc_in;

   logic        a_valid, b_valid, c_valid;
   logic [31:0] a_insn, b_insn, c_insn;
   logic [11:0] a_pc, b_pc, c_pc;
   logic [63:0] a_data;
   logic [63:0] b_data;
   logic [15:0] c_data;
   logic [7:0]  a_cnt;
   logic [1:0]  b_cnt;
   logic [7:0]  c_cnt;

   int checks;
   int errors;

   // Default configuration: NUM_DATA=2, DATA_W=32, STALL_CNT_W=8
   pipe_stage_reg dut_a (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .insn_in(insn_in), .pc_in(pc_in), .data_in(da_in),
      .valid_out(a_valid), .insn_out(a_insn), .pc_out(a_pc), .data_out(a_data),
      .stall_cnt(a_cnt)
   );

   // NUM_DATA=4, DATA_W=16, with a narrow counter to exercise saturation
   pipe_stage_reg #(.DATA_W(16), .NUM_DATA(4), .STALL_CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .insn_in(insn_in), .pc_in(pc_in), .data_in(db_in),
      .valid_out(b_valid), .insn_out(b_insn), .pc_out(b_pc), .data_out(b_data),
      .stall_cnt(b_cnt)
   );

   // NUM_DATA=1, DATA_W=16
   pipe_stage_reg #(.DATA_W(16), .NUM_DATA(1)) dut_c (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .valid_in(valid_in), .insn_in(insn_in), .pc_in(pc_in), .data_in(dc_in),
      .valid_out(c_valid), .insn_out(c_insn), .pc_out(c_pc), .data_out(c_data),
      .stall_cnt(c_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected counter value after k held-valid edges for a counter saturating at mx
   function automatic logic [63:0] cexp(input int k, input int mx);
`ifdef PIPE_STALL_CNT_EN
      return (k > mx) ? 64'(mx) : 64'(k);
`else
      return 64'd0;
`endif
   endfunction

   task automatic check_all(input string tag, input logic v, input logic [31:0] insn,
                            input logic [11:0] pc, input logic [63:0] da,
                            input logic [63:0] db, input logic [15:0] dc, input int k);
      chk({tag, ".a_valid"}, 64'(a_valid), 64'(v));
      chk({tag, ".b_valid"}, 64'(b_valid), 64'(v));
      chk({tag, ".c_valid"}, 64'(c_valid), 64'(v));
      chk({tag, ".a_insn"},  64'(a_insn),  64'(insn));
      chk({tag, ".c_insn"},  64'(c_insn),  64'(insn));
      chk({tag, ".a_pc"},    64'(a_pc),    64'(pc));
      chk({tag, ".b_pc"},    64'(b_pc),    64'(pc));
      chk({tag, ".a_data"},  a_data,       da);
      chk({tag, ".b_data"},  b_data,       db);
      chk({tag, ".c_data"},  64'(c_data),  64'(dc));
      chk({tag, ".a_cnt"},   64'(a_cnt),   cexp(k, 255));
      chk({tag, ".b_cnt"},   64'(b_cnt),   cexp(k, 3));
      chk({tag, ".c_cnt"},   64'(c_cnt),   cexp(k, 255));
   endtask

   task automatic set_in(input logic v, input logic [31:0] insn, input logic [11:0] pc,
                         input logic [63:0] da, input logic [63:0] db, input logic [15:0] dc);
      valid_in = v;
      insn_in  = insn;
      pc_in    = pc;
      da_in    = da;
      db_in    = db;
      dc_in    = dc;
   endtask

   // Advance one active edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      stall  = 1'b0;
      flush  = 1'b0;
      set_in(1'b0, 32'h0, 12'h0, 64'h0, 64'h0, 16'h0);

      // Reset asserted mid-cycle clears outputs without a clock edge
      #3;
      reset = 1'b1;
      #1;
      check_all("reset", 1'b0, 32'h0, 12'h000, 64'h0, 64'h0, 16'h0, 0);
      step();
      reset = 1'b0;

      // Reset then load
      set_in(1'b1, 32'h00A1_2345, 12'h004, 64'h1234_5678_DEAD_BEEF,
             64'h4444_3333_2222_1111, 16'hABCD);
      step();
      check_all("load1", 1'b1, 32'h00A1_2345, 12'h004, 64'h1234_5678_DEAD_BEEF,
                64'h4444_3333_2222_1111, 16'hABCD, 0);

      // Stall hold: load pc 010, then stall 3 edges while inputs change
      set_in(1'b1, 32'h0000_0013, 12'h010, 64'hBBBB_0002_AAAA_0001,
             64'h0008_0007_0006_0005, 16'h0F0F);
      step();
      check_all("load2", 1'b1, 32'h0000_0013, 12'h010, 64'hBBBB_0002_AAAA_0001,
                64'h0008_0007_0006_0005, 16'h0F0F, 0);
      stall = 1'b1;
      set_in(1'b1, 32'h0010_0093, 12'h020, 64'h2222_2222_1111_1111,
             64'hDDDD_CCCC_BBBB_AAAA, 16'hF0F0);
      for (int k = 1; k <= 3; k++) begin
         step();
         check_all($sformatf("stall%0d", k), 1'b1, 32'h0000_0013, 12'h010,
                   64'hBBBB_0002_AAAA_0001, 64'h0008_0007_0006_0005, 16'h0F0F, k);
      end
      stall = 1'b0;
      step();
      check_all("stall_rel", 1'b1, 32'h0010_0093, 12'h020, 64'h2222_2222_1111_1111,
                64'hDDDD_CCCC_BBBB_AAAA, 16'hF0F0, 0);

      // Flush overrides a simultaneous stall
      stall = 1'b1;
      flush = 1'b1;
      set_in(1'b1, 32'h1234_5678, 12'h030, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
      step();
      check_all("flush", 1'b0, 32'h0, 12'h000, 64'h0, 64'h0, 16'h0, 0);

      // Stalling a bubble holds it, and the counter stays at 0
      flush = 1'b0;
      step();
      check_all("stall_bubble", 1'b0, 32'h0, 12'h000, 64'h0, 64'h0, 16'h0, 0);

      // Load after the flush
      stall = 1'b0;
      set_in(1'b1, 32'h0020_0113, 12'h030, 64'h3333_3333_4444_4444,
             64'h1234_5678_9ABC_DEF0, 16'h5A5A);
      step();
      check_all("load3", 1'b1, 32'h0020_0113, 12'h030, 64'h3333_3333_4444_4444,
                64'h1234_5678_9ABC_DEF0, 16'h5A5A, 0);

      // With valid_in=0 the payload is still copied
      set_in(1'b0, 32'h0030_0193, 12'h034, 64'h5555_5555_6666_6666,
             64'hFFFF_0000_FFFF_0000, 16'hA5A5);
      step();
      check_all("load_inv", 1'b0, 32'h0030_0193, 12'h034, 64'h5555_5555_6666_6666,
                64'hFFFF_0000_FFFF_0000, 16'hA5A5, 0);

      // Saturation: the 2-bit counter on dut_b stops at 3
      set_in(1'b1, 32'h0040_0213, 12'h040, 64'h7777_7777_8888_8888,
             64'h0001_0002_0003_0004, 16'h1234);
      step();
      check_all("load4", 1'b1, 32'h0040_0213, 12'h040, 64'h7777_7777_8888_8888,
                64'h0001_0002_0003_0004, 16'h1234, 0);
      stall = 1'b1;
      set_in(1'b1, 32'h0044_0293, 12'h044, 64'h0BAD_F00D_CAFE_BABE,
             64'h0A0A_0B0B_0C0C_0D0D, 16'h4321);
      for (int k = 1; k <= 6; k++) begin
         step();
         check_all($sformatf("sat%0d", k), 1'b1, 32'h0040_0213, 12'h040,
                   64'h7777_7777_8888_8888, 64'h0001_0002_0003_0004, 16'h1234, k);
      end
      stall = 1'b0;
      step();
      check_all("sat_rel", 1'b1, 32'h0044_0293, 12'h044, 64'h0BAD_F00D_CAFE_BABE,
                64'h0A0A_0B0B_0C0C_0D0D, 16'h4321, 0);

      // Async reset mid-stall
      stall = 1'b1;
      set_in(1'b1, 32'h0048_0313, 12'h048, 64'h0, 64'h0, 16'h0);
      for (int k = 1; k <= 2; k++) begin
         step();
         check_all($sformatf("pre_rst%0d", k), 1'b1, 32'h0044_0293, 12'h044,
                   64'h0BAD_F00D_CAFE_BABE, 64'h0A0A_0B0B_0C0C_0D0D, 16'h4321, k);
      end
      #2;
      reset = 1'b1;
      #1;
      check_all("rst_mid", 1'b0, 32'h0, 12'h000, 64'h0, 64'h0, 16'h0, 0);
      #1;
      reset = 1'b0;
      stall = 1'b0;
      set_in(1'b1, 32'h0050_0393, 12'h050, 64'h9999_9999_AAAA_AAAA,
             64'h0A0B_0C0D_0E0F_1011, 16'h7777);
      step();
      check_all("post_rst", 1'b1, 32'h0050_0393, 12'h050, 64'h9999_9999_AAAA_AAAA,
                64'h0A0B_0C0D_0E0F_1011, 16'h7777, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the processor pipeline, replacing the fixed per-stage latches (F/D, D/X, X/M, M/W). It carries a valid bit, instruction word, PC and a configurable number of operand words. It adds stall (hold), flush (bubble insertion) and an optional saturating stall-cycle counter for hazard profiling. One instance sits between each pair of adjacent pipeline stages.

## Interface
Parameters:
- INSN_W, 32, instruction word width
- PC_W, 12, PC width
- DATA_W, 32, width of each operand word
- NUM_DATA, 2, number of operand words carried (1..4)
- STALL_CNT_W, 8, stall counter width (used only with PIPE_STALL_CNT_EN)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents this cycle
- flush  in  1  replace contents with a bubble at the next edge
- valid_in  in  1  upstream slot holds a real instruction
- insn_in  in  INSN_W  instruction from upstream stage
- pc_in  in  PC_W  PC+4 from upstream stage
- data_in  in  NUM_DATA*DATA_W  operand words; word k at bits [k*DATA_W +: DATA_W]
- valid_out  out  1  registered valid
- insn_out  out  INSN_W  registered instruction
- pc_out  out  PC_W  registered PC
- data_out  out  NUM_DATA*DATA_W  registered operands, same packing as data_in
- stall_cnt  out  STALL_CNT_W  consecutive held-valid cycles

## Operation
- Each edge performs exactly one action. Priority: reset > flush > stall > load.
- Reset (asynchronous, any time): valid_out=0, insn_out=0, pc_out=0, data_out=0, stall_cnt=0. Takes effect immediately, no clock required. Release is sampled normally at the next edge.
- Flush: load a bubble. valid_out=0 and all of insn_out, pc_out and data_out are 0. An all-zero insn is the ISA nop. Flush overrides a simultaneous stall, so a flushed stage never holds a killed instruction.
- Stall (no flush): all outputs keep their values, including valid_out.
- Load (no flush, no stall): valid_out<=valid_in, and insn, pc and data are copied from their inputs. With valid_in=0 the payload is still copied, and downstream qualifies it with valid_out.
- No combinational path from any input to any output.
- Stall counter, when compiled in:
  - stall=1, flush=0 and valid_out=1: increment, saturating at 2^STALL_CNT_W-1 with no wrap.
  - stall=1 while valid_out=0: hold.
  - Any load or flush: clear to 0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- A stall asserted for k cycles holds contents across exactly k edges. The load occurs on the first edge with stall=0.
- Flush asserted for one cycle produces exactly one bubble cycle, provided no further flush or stall follows.
- stall_cnt updates on the same edge as the hold it counts. After k held-valid edges, stall_cnt reads min(k, 2^STALL_CNT_W-1).
- Reset asserted mid-stall or mid-flush discards all state. The first edge after release performs a normal action per priority.

## Configuration
- PIPE_STALL_CNT_EN defined: stall counter register implemented as described, and stall_cnt is live.
- PIPE_STALL_CNT_EN undefined: no counter flops. stall_cnt is tied to 0 and the STALL_CNT_W port width is retained so instantiations are unchanged.

## Test plan
- Reset then load: assert reset mid-cycle -> all outputs 0 immediately. Release, drive valid_in=1, insn_in=32'h00A1_2345, pc_in=12'h004, data word0=32'hDEAD_BEEF, word1=32'h1234_5678 -> one edge later outputs match exactly, valid_out=1.
- Stall hold: load pc 12'h010, then stall=1 for 3 cycles while inputs change -> outputs unchanged for 3 edges. With the macro on, stall_cnt=1,2,3. Release -> new inputs appear and stall_cnt=0.
- Flush over stall: valid contents, stall=1 and flush=1 together -> next edge valid_out=0, insn_out=0, pc_out=0, data_out=0, stall_cnt=0.
- Saturation: STALL_CNT_W=2, valid_out=1, stall held 6 edges -> stall_cnt 1,2,3,3,3,3.
- Async reset mid-stall: 2 stalled cycles, then pulse reset between edges -> outputs and stall_cnt 0 before the next edge. Release with stall=0, valid_in=1 -> normal load one edge later.
- Parameter sweep: NUM_DATA=1 and NUM_DATA=4 with DATA_W=16 -> each word k passes at [k*16 +: 16], with no cross-word corruption under load, stall and flush.
